// File: rtl/shift_add_mul8_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_WIDTH_DEF = 8;

endpackage

// File: rtl/shift_add_mul8_add_w.sv
// Parameterised WIDTH-bit adder with carry-in and carry-out.
module add_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Full add; the carry-out is the extra top bit of the widened sum.
  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/shift_add_mul8.sv
// Sequential shift-and-add unsigned multiplier, one W-bit add per clock,
// 2*WIDTH-bit product after WIDTH iterations, valid/ready on both sides.
// Optional feature macro: SHIFT_ADD_MUL8_ZERO_BYPASS_EN -- a zero operand
// skips the iterations and goes straight to DONE with a zero product.
import shift_add_mul8_pkg::*;

module shift_add_mul8 #(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     sum;
  logic                 carry;

  // The upper half of acc is the running partial product; the lower half
  // still holds the unconsumed multiplier bits, LSB first.
  add_w #(.WIDTH(WIDTH)) u_add (
    .x    (acc[2*WIDTH-1:WIDTH]),
    .y    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Control FSM and datapath: accept, iterate WIDTH times, hold until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            cnt   <= '0;
`ifdef SHIFT_ADD_MUL8_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              acc   <= '0;
              state <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b};
              state <= RUN;
            end
`else
            acc   <= {{WIDTH{1'b0}}, b};
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // Carry-out of the add becomes the new MSB, so nothing is lost.
          if (acc[0]) begin
            acc <= {carry, sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status flags decode straight from state; p is the register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN);
    p         = acc;
  end

endmodule
